// File: rtl/dii_pkg.sv
// Shared DII constants for the register responder: word width, packet
// type/subtype codes and the base register map.
package dii_pkg;

  localparam int DII_W = 16;

  // Header type field value for register access packets
  localparam logic [1:0] TYPE_REG = 2'b00;

  // Request subtypes
  localparam logic [3:0] REQ_READ  = 4'd0;
  localparam logic [3:0] REQ_WRITE = 4'd1;

  // Response subtypes
  localparam logic [3:0] RESP_READ_OK   = 4'd8;
  localparam logic [3:0] RESP_READ_ERR  = 4'd9;
  localparam logic [3:0] RESP_WRITE_OK  = 4'd10;
  localparam logic [3:0] RESP_WRITE_ERR = 4'd11;

  // Base register addresses
  localparam logic [DII_W-1:0] ADDR_VENDOR  = 16'h0000;
  localparam logic [DII_W-1:0] ADDR_TYPE    = 16'h0001;
  localparam logic [DII_W-1:0] ADDR_VERSION = 16'h0002;
  localparam logic [DII_W-1:0] ADDR_CS      = 16'h0003;

  // Read-only identification values
  localparam logic [DII_W-1:0] MOD_VENDOR  = 16'h0001;
  localparam logic [DII_W-1:0] MOD_TYPE    = 16'h0000;
  localparam logic [DII_W-1:0] MOD_VERSION = 16'h0000;

  // Responder FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRC,
    ST_HDR,
    ST_ADDR,
    ST_WDATA,
    ST_DRAIN,
    ST_RESP
  } dii_state_e;

  // Response header word: type REG, given subtype, low bits zero
  function automatic logic [DII_W-1:0] resp_header(input logic [3:0] sub);
    return {TYPE_REG, sub, 10'h000};
  endfunction

endpackage

// File: rtl/dii_reg_responder.sv
// Register-access endpoint on a debug ring local port. Receives REG
// read/write request packets addressed to this node and answers with a
// 3- or 4-word response packet. Both ports transfer a word when valid and
// ready are high together in the same cycle; out_valid, once raised, stays
// high with stable data/first/last until out_ready takes the word.
module dii_reg_responder
  import dii_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       id,
  input  logic [DII_W-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  output logic             in_ready,
  output logic [DII_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  input  logic             out_ready,
  output logic [DII_W-1:0] ctrl
);

  // FSM state; kept as a plain named signal so checkers can bind to it
  dii_state_e       state;
  logic [DII_W-1:0] src_q;
  logic [DII_W-1:0] addr_q;
  logic [DII_W-1:0] resp_data;
  logic [3:0]       resp_sub;
  logic             is_write;
  logic [1:0]       resp_idx;

  logic [DII_W-1:0] node_addr;
  logic             xfer_in;
  logic [1:0]       hdr_type;
  logic [3:0]       hdr_sub;
  logic             go_resp;

  assign node_addr = {6'b0, id};
  assign xfer_in   = in_valid && in_ready;
  assign hdr_type  = in_data[15:14];
  assign hdr_sub   = in_data[13:10];

  // A final request word (complete or drained) launches the response
  assign go_resp = xfer_in && !in_first && in_last &&
                   ((state == ST_DRAIN) || (state == ST_WDATA) ||
                    ((state == ST_ADDR) && !is_write));

  // Request parsing, register file update and response sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      ctrl      <= '0;
      src_q     <= '0;
      addr_q    <= '0;
      resp_data <= '0;
      resp_sub  <= '0;
      is_write  <= 1'b0;
      resp_idx  <= '0;
    end else if (state == ST_RESP) begin
      // out_valid is always high here; advance only on acceptance
      if (out_ready) begin
        case (resp_idx)
          2'd0: begin
            out_data  <= node_addr;
            out_first <= 1'b0;
            resp_idx  <= 2'd1;
          end
          2'd1: begin
            out_data <= resp_header(resp_sub);
            out_last <= (resp_sub != RESP_READ_OK);
            resp_idx <= 2'd2;
          end
          default: begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              in_ready  <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              out_data <= resp_data;
              out_last <= 1'b1;
              resp_idx <= 2'd3;
            end
          end
        endcase
      end
    end else begin
      in_ready <= 1'b1;
      if (xfer_in) begin
        if (in_first) begin
          // Any first word restarts parsing, abandoning a partial packet
          state <= ((in_data == node_addr) && !in_last) ? ST_SRC : ST_IDLE;
        end else begin
          case (state)
            ST_SRC: begin
              src_q <= in_data;
              state <= in_last ? ST_IDLE : ST_HDR;
            end
            ST_HDR: begin
              if (in_last || (hdr_type != TYPE_REG) ||
                  ((hdr_sub != REQ_READ) && (hdr_sub != REQ_WRITE))) begin
                state <= ST_IDLE;
              end else begin
                is_write <= (hdr_sub == REQ_WRITE);
                state    <= ST_ADDR;
              end
            end
            ST_ADDR: begin
              addr_q <= in_data;
              if (!is_write) begin
                if (in_last) begin
                  resp_sub <= RESP_READ_OK;
                  case (in_data)
                    ADDR_VENDOR:  resp_data <= MOD_VENDOR;
                    ADDR_TYPE:    resp_data <= MOD_TYPE;
                    ADDR_VERSION: resp_data <= MOD_VERSION;
                    ADDR_CS:      resp_data <= ctrl;
                    default:      resp_sub  <= RESP_READ_ERR;
                  endcase
                end else begin
                  // Over-long read: swallow the rest, then report error
                  resp_sub <= RESP_READ_ERR;
                  state    <= ST_DRAIN;
                end
              end else begin
                state <= in_last ? ST_IDLE : ST_WDATA;
              end
            end
            ST_WDATA: begin
              if (!in_last) begin
                resp_sub <= RESP_WRITE_ERR;
                state    <= ST_DRAIN;
              end else if (addr_q == ADDR_CS) begin
                ctrl     <= in_data;
                resp_sub <= RESP_WRITE_OK;
              end else begin
                resp_sub <= RESP_WRITE_ERR;
              end
            end
            default: ;  // IDLE strays and DRAIN words are simply consumed
          endcase
        end
        if (go_resp) begin
          state     <= ST_RESP;
          in_ready  <= 1'b0;
          out_valid <= 1'b1;
          out_first <= 1'b1;
          out_last  <= 1'b0;
          out_data  <= src_q;
          resp_idx  <= 2'd0;
        end
      end
    end
  end

endmodule
